// File: rtl/ddr3_capture_ring_if.sv
// Capture ring bus: listen/strobe/din come from the PHY and controller side; rd_en pops beats.
// The slave modport is the ring; the master modport drives capture and read requests.
interface ddr3_capture_ring_if #(
  parameter int DW = 16
);
  logic          listen;
  logic          strobe;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          burst_avail;
  logic          overflow;

  modport master (
    output listen, strobe, din, rd_en,
    input  dout, dout_valid, burst_avail, overflow
  );

  modport slave (
    input  listen, strobe, din, rd_en,
    output dout, dout_valid, burst_avail, overflow
  );
endinterface

// File: rtl/ddr3_capture_ring.sv
// DQS-clocked burst capture into an NSLOT ring; beats pop one per clk, dout registered 1 clk after rd_en, rd_en ignored while no burst is available.
// DQS_DELAY_EN inserts a five-cell CLKBUF2 delay chain on strobe ahead of the filter; listens with no free slot set sticky overflow.
module ddr3_capture_ring #(
  parameter int DW    = 16,
  parameter int BL    = 8,
  parameter int NSLOT = 2
) (
  input logic                clk,
  input logic                reset,
  ddr3_capture_ring_if.slave bus
);
  localparam int HB = BL / 2;
  localparam int CW = $clog2(HB);
  localparam int BW = $clog2(BL);
  localparam int SW = $clog2(NSLOT);

  logic             strobe_d;
  logic             armed;
  logic             fstrobe;
  logic             arm_tog;
  logic             done_tog;
  logic             done_s1;
  logic             done_s2;
  logic             done_seen;
  logic [CW-1:0]    count;
  logic [SW-1:0]    wr_slot;
  logic [SW-1:0]    wr_slot_q;
  logic [SW-1:0]    rd_slot;
  logic [BW-1:0]    rd_beat;
  logic [CW-1:0]    rd_pair;
  logic [SW:0]      alloc_cnt;
  logic [NSLOT-1:0] full;
  logic [DW-1:0]    dout_q;
  logic             dout_valid_q;
  logic             overflow_q;
  logic             busy;
  logic             pop;
  logic             room;
  logic             accept;

  logic [DW-1:0] mem_even [NSLOT*HB];
  logic [DW-1:0] mem_odd  [NSLOT*HB];

`ifdef DQS_DELAY_EN
  logic [5:0] dly;
  assign dly[0] = bus.strobe;
  (* dont_touch = "true" *) CLKBUF2 DELAY0 (.A(dly[0]), .Y(dly[1]));
  (* dont_touch = "true" *) CLKBUF2 DELAY1 (.A(dly[1]), .Y(dly[2]));
  (* dont_touch = "true" *) CLKBUF2 DELAY2 (.A(dly[2]), .Y(dly[3]));
  (* dont_touch = "true" *) CLKBUF2 DELAY3 (.A(dly[3]), .Y(dly[4]));
  (* dont_touch = "true" *) CLKBUF2 DELAY4 (.A(dly[4]), .Y(dly[5]));
  assign strobe_d = dly[5];
`else
  assign strobe_d = bus.strobe;
`endif

  // Armed while an allocation toggle is outstanding; the final falling edge flips done_tog and closes the gate.
  assign armed   = arm_tog ^ done_tog;
  assign fstrobe = strobe_d & armed;

  always_ff @(posedge fstrobe) begin
    mem_even[{wr_slot_q, count}] <= bus.din;
  end

  always_ff @(negedge fstrobe) begin
    mem_odd[{wr_slot_q, count}] <= bus.din;
  end

  always_ff @(negedge fstrobe or posedge reset) begin
    if (reset) begin
      count    <= '0;
      done_tog <= 1'b0;
    end else if (count == CW'(HB - 1)) begin
      count    <= '0;
      done_tog <= ~done_tog;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Busy uses the synchronised completion so a new allocation never races the full-flag update.
  assign busy    = arm_tog ^ done_seen;
  assign pop     = bus.rd_en & full[rd_slot] & (rd_beat == BW'(BL - 1));
  assign room    = (alloc_cnt < (SW + 1)'(NSLOT)) | pop;
  assign accept  = bus.listen & ~busy & room;
  assign rd_pair = rd_beat[BW-1:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_tog      <= 1'b0;
      done_s1      <= 1'b0;
      done_s2      <= 1'b0;
      done_seen    <= 1'b0;
      wr_slot      <= '0;
      wr_slot_q    <= '0;
      rd_slot      <= '0;
      rd_beat      <= '0;
      alloc_cnt    <= '0;
      full         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      done_s1   <= done_tog;
      done_s2   <= done_s1;
      done_seen <= done_s2;
      if (done_s2 != done_seen) begin
        full[wr_slot_q] <= 1'b1;
      end

      if (accept) begin
        arm_tog   <= ~arm_tog;
        wr_slot_q <= wr_slot;
        wr_slot   <= wr_slot + 1'b1;
      end else if (bus.listen) begin
        overflow_q <= 1'b1;
      end

      if (accept && !pop) begin
        alloc_cnt <= alloc_cnt + 1'b1;
      end else if (pop && !accept) begin
        alloc_cnt <= alloc_cnt - 1'b1;
      end

      dout_valid_q <= 1'b0;
      if (bus.rd_en && full[rd_slot]) begin
        dout_valid_q <= 1'b1;
        dout_q       <= rd_beat[0] ? mem_odd[{rd_slot, rd_pair}] : mem_even[{rd_slot, rd_pair}];
        rd_beat      <= rd_beat + 1'b1;
        if (pop) begin
          full[rd_slot] <= 1'b0;
          rd_slot       <= rd_slot + 1'b1;
        end
      end
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.burst_avail = full[rd_slot];
  assign bus.overflow    = overflow_q;
endmodule

// File: doc/ddr3_capture_ring.md
DDR3_CAPTURE_RING -- requirements
Module: ddr3_capture_ring

Interface
REQ-001 Parameter DW, 16, DQ data width in bits (1..64).
REQ-002 Parameter BL, 8, beats per burst; legal values 4 and 8.
REQ-003 Parameter NSLOT, 2, burst slots in the ring; power of two, 2..8.
REQ-004 Port clk  input  1  controller clock; all read-side and allocation logic runs on its rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port listen  input  1  one-clk pulse, synchronous to clk; arms capture of the next burst.
REQ-007 Port strobe  input  1  DQS from the pad; one rising and one falling edge per beat pair.
REQ-008 Port din  input  DW  DQ data, sampled on both edges of the filtered strobe.
REQ-009 Port rd_en  input  1  pops one beat per clk while burst_avail=1.
REQ-010 Port dout  output  DW  registered read beat.
REQ-011 Port dout_valid  output  1  dout holds a popped beat this cycle.
REQ-012 Port burst_avail  output  1  the oldest slot holds a complete burst.
REQ-013 Port overflow  output  1  sticky; a listen arrived while all NSLOT slots were allocated.

Function
REQ-014 Strobe filter: fStrobe = delayed strobe AND (armed); armed is set asynchronously by listen and cleared on the fStrobe falling edge that completes beat BL.
REQ-015 The strobe domain holds a beat-pair counter (0..BL/2-1); rising fStrobe writes din to beat 2*count of slot wr_slot, and falling fStrobe writes din to beat 2*count+1.
REQ-016 The counter increments on each falling fStrobe, wraps to 0 after BL/2-1, and on wrap toggles done_tog.
REQ-017 done_tog is synchronised into clk with two flops; each detected toggle marks slot wr_slot_q (captured at allocation) full, 2 to 3 clk after the last strobe edge.
REQ-018 Allocation happens in clk: on listen with alloc_cnt<NSLOT, wr_slot advances modulo NSLOT (first burst after reset uses slot 0) and alloc_cnt increments.
REQ-019 On listen with alloc_cnt==NSLOT: no slot is armed, strobe edges are ignored, overflow is set to 1, and no stored data is modified.
REQ-020 A listen that arrives while a burst is still being captured (armed=1) is treated as an overflow and is otherwise ignored.
REQ-021 burst_avail = full[rd_slot]; rd_en while burst_avail=0 is ignored and dout_valid stays 0.
REQ-022 Read latency: rd_en sampled high at edge N gives dout/dout_valid valid after edge N, holding beat rd_beat of rd_slot; rd_beat then increments.
REQ-023 After beat BL-1 is popped: full[rd_slot] clears, rd_slot advances modulo NSLOT, and alloc_cnt decrements on the same edge.
REQ-024 A simultaneous listen and final-beat pop on the same edge nets alloc_cnt unchanged and does not raise overflow.
REQ-025 Beats are returned in capture order, bursts in FIFO order; the wrap from slot NSLOT-1 to slot 0 is seamless.

Reset
REQ-026 Reset clears: armed, count, done_tog, both sync flops, wr_slot, rd_slot, rd_beat, alloc_cnt, all full flags, overflow, dout_valid and dout (all to 0).
REQ-027 Reset mid-burst aborts the capture immediately, and no partial burst is ever reported.
REQ-028 Slot data storage is not reset.
REQ-029 Overflow clears only on reset.

Configuration
REQ-030 Macro DQS_DELAY_EN defined: strobe passes through a chain of five CLKBUF2 cell instances named DELAY0..DELAY4 (kept dont_touch) before the filter.
REQ-031 Macro DQS_DELAY_EN undefined: the delay chain is absent and strobe feeds the filter directly; all other behaviour is identical.

Verification
REQ-032 Defaults; listen, then 4 strobe cycles with din=0x1111..0x8888 per edge; wait 4 clk, then rd_en for 8 clk -> burst_avail=1, dout=0x1111..0x8888 in order, dout_valid 8 cycles, then burst_avail=0.
REQ-033 Strobe toggles 4 cycles with no listen -> burst_avail stays 0 and the storage contents are unchanged.
REQ-034 Three bursts captured with no reads (NSLOT=2) -> overflow=1 after the third listen; reading returns bursts 1 and 2 intact.
REQ-035 Five bursts written and read alternately -> slot wrap is correct and the data matches every burst; on the pop of burst 2's final beat, the same-edge listen leaves overflow=0.
REQ-036 BL=4, DW=32 -> 2 strobe cycles complete a burst, and 4 pops return the data in order.
REQ-037 Reset asserted after 2 of 4 strobe cycles -> all outputs 0; the next full burst is captured into slot 0 and read back correctly.
